// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: unified memory-bus front end. Arbitrates NUM_PORTS
// requesters (port 0 = fixed-priority debug, others round-robin) onto one
// bus and decodes each access to a RAM target or an IO target.
//
// Ports:
//   clk_i-style naming is not used here; the port list is fixed by the bus:
//   clk, rst          : clock, async active-high reset
//   req_*             : per-port level requests, flattened vectors, port i
//                       at [i*W +: W]; req_done/req_err pulse for one cycle
//   grant_id, busy    : current owner and "not idle" status
//   ram_*             : strobe/complete RAM protocol, addr/data latched
//   io_*              : addr_valid/din_ready IO protocol, addr/data latched
module mem_bus_arbiter #(
  parameter int                NUM_PORTS  = 3,
  parameter int                ADDR_W     = 64,
  parameter int                DATA_W     = 64,
  parameter logic [ADDR_W-1:0] IO_MASK    = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [ADDR_W-1:0] IO_MATCH   = 64'hFFFF_FFFF_FFFF_0000,
  parameter int                IO_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_rstrobe,
  input  logic [NUM_PORTS-1:0]          req_wstrobe,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [NUM_PORTS*2-1:0]        req_width,
  output logic [NUM_PORTS-1:0]          req_done,
  output logic [NUM_PORTS-1:0]          req_err,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [1:0]                    ram_width,
  output logic                          ram_rstrobe,
  output logic                          ram_wstrobe,
  input  logic [DATA_W-1:0]             ram_rdata,
  input  logic                          ram_complete,
  output logic [ADDR_W-1:0]             io_addr,
  output logic [DATA_W-1:0]             io_dout,
  output logic                          io_addr_valid,
  output logic                          io_write,
  input  logic [DATA_W-1:0]             io_din,
  input  logic                          io_din_ready
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RAM_WAIT,
    S_IO_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          width_q, width_d;
  logic                write_q, write_d;
  logic                io_q, io_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] pend;
  logic                 found;
  logic [GW-1:0]        win;
  logic [GW:0]          idx;
  logic [ADDR_W-1:0]    sel_addr;

  assign pend = req_rstrobe | req_wstrobe;

  // Port 0 always wins; otherwise scan ports rr, rr+1, ... folding
  // the index back into 1..NUM_PORTS-1 so port 0 is never revisited.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    if (pend[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS - 1; k++) begin
        idx = {1'b0, rr_q} + (GW+1)'(k);
        if (idx >= (GW+1)'(NUM_PORTS))
          idx = idx - (GW+1)'(NUM_PORTS - 1);
        if (!found && pend[idx[GW-1:0]]) begin
          found = 1'b1;
          win   = idx[GW-1:0];
        end
      end
    end
  end

  assign sel_addr = req_addr[win*ADDR_W +: ADDR_W];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    width_d = width_q;
    write_d = write_q;
    io_d    = io_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          addr_d  = sel_addr;
          wdata_d = req_wdata[win*DATA_W +: DATA_W];
          width_d = req_width[win*2 +: 2];
          write_d = req_wstrobe[win];
          io_d    = (sel_addr & IO_MASK) == IO_MATCH;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (io_q) begin
          // Narrow IO is rejected without touching the IO bus.
          if (width_q != 2'd0) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_IO_WAIT;
          end
        end else begin
          state_d = S_RAM_WAIT;
        end
      end
      S_RAM_WAIT: begin
        if (ram_complete) begin
          rdata_d = ram_rdata;
          state_d = S_RESP;
        end
      end
      S_IO_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Ready in the final allowed cycle still counts as success.
        if (io_din_ready) begin
          rdata_d = io_din;
          state_d = S_RESP;
        end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (grant_q != '0) begin
          if (grant_q == GW'(NUM_PORTS - 1))
            rr_d = GW'(1);
          else
            rr_d = grant_q + GW'(1);
        end
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= GW'(1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      width_q <= '0;
      write_q <= 1'b0;
      io_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      width_q <= width_d;
      write_q <= write_d;
      io_q    <= io_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [NUM_PORTS-1:0] grant_oh;
  logic                 in_resp;

  assign grant_oh = NUM_PORTS'(1) << grant_q;
  assign in_resp  = state_q == S_RESP;

  assign req_done      = in_resp ? grant_oh : '0;
  assign req_err       = (in_resp && err_q) ? grant_oh : '0;
  assign req_rdata     = rdata_q;
  assign grant_id      = grant_q;
  assign busy          = state_q != S_IDLE;
  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_width     = width_q;
  assign ram_rstrobe   = (state_q == S_ISSUE) && !io_q && !write_q;
  assign ram_wstrobe   = (state_q == S_ISSUE) && !io_q && write_q;
  assign io_addr       = addr_q;
  assign io_dout       = wdata_q;
  assign io_addr_valid = state_q == S_IO_WAIT;
  assign io_write      = (state_q == S_IO_WAIT) && write_q;

endmodule
